fll_cfg_ctrl: RTL and testbench

Sequencer that owns the FLL configuration port of the clock/reset generator. It accepts single register read/write commands from the peripheral subsystem's SoC-control register file and runs the four-phase req/ack handshake on the FLL configuration bus. After frequency-changing writes it optionally waits for FLL lock. It enforces ack and lock timeouts and flags loss of lock as an interrupt pulse.

---
 rtl/fll_cfg_ctrl_if.sv | 31 +++
 rtl/fll_cfg_ctrl.sv | 179 +++++++++++++++++
 tb/tb_fll_cfg_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fll_cfg_ctrl_if.sv
// ============================================================================
//  Module      : fll_cfg_ctrl_if
//  Description : Command/response handshake between the SoC-control register
//                file (master) and the FLL configuration sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fll_cfg_ctrl_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_wrn_i;
    logic [1:0]  cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_err_o;

    modport master (
        output cmd_valid_i, cmd_wrn_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_wrn_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

`default_nettype wire

// File: rtl/fll_cfg_ctrl.sv
// ============================================================================
//  Module      : fll_cfg_ctrl
//  Description : Single-outstanding sequencer for the FLL configuration port.
//                Runs the four-phase req/ack handshake, optionally waits for
//                FLL lock after frequency-changing writes, enforces ack/lock
//                timeouts and pulses on loss of lock.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fll_cfg_ctrl #(
    parameter int         ACK_TIMEOUT    = 1024,
    parameter int         LOCK_TIMEOUT   = 65535,
    parameter logic [3:0] LOCK_WAIT_MASK = 4'b0011
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    fll_cfg_ctrl_if.slave    cmd,
    output logic             fll_req_o,
    output logic             fll_wrn_o,
    output logic [1:0]       fll_add_o,
    output logic [31:0]      fll_data_o,
    input  wire logic        fll_ack_i,
    input  wire logic [31:0] fll_r_data_i,
    input  wire logic        fll_lock_i,
    output logic             lock_o,
    output logic             lock_lost_o
);

    localparam int MAX_TO = (ACK_TIMEOUT > LOCK_TIMEOUT) ? ACK_TIMEOUT : LOCK_TIMEOUT;
    localparam int CNT_W  = $clog2(MAX_TO + 1);

    // Timeouts fire in the N-th cycle spent in a state (counter reads N-1 then)
    localparam logic [CNT_W-1:0] ACK_LIM    = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LIM   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_BLIND = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_REL    = 3'd2;
    localparam logic [2:0] S_REL_TO = 3'd3;
    localparam logic [2:0] S_LOCK   = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_ACK  = 2'b01;
    localparam logic [1:0] ERR_LOCK = 2'b10;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             lock_meta;
    logic             lock_sync;
    logic             lock_prev;
    logic [31:0]      rdata;
    logic [1:0]       err;
    logic             lock_wait;
    logic             lock_seen;
    logic             relock_window;

    // The in-flight command is a write whose target needs to relock
    assign lock_wait = ~fll_wrn_o & LOCK_WAIT_MASK[fll_add_o];
    // Lock only counts once the blind window has passed, so a pre-write lock is not trusted
    assign lock_seen = lock_sync & (cnt >= LOCK_BLIND);
    // A lock-waiting write may knock the FLL out of lock as soon as it is issued,
    // so the loss is expected throughout that transaction, not only in LOCK
    assign relock_window = (state == S_LOCK) |
                           (lock_wait & ((state == S_REQ) | (state == S_REL)));

    assign cmd.cmd_ready_o = (state == S_IDLE);
    assign cmd.rsp_valid_o = (state == S_RESP);
    assign cmd.rsp_rdata_o = rdata;
    assign cmd.rsp_err_o   = err;
    assign fll_req_o       = (state == S_REQ);
    assign lock_o          = lock_sync;
    assign lock_lost_o     = lock_prev & ~lock_sync & ~relock_window;

    // Next-state decode for the handshake sequencer
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (cmd.cmd_valid_i) state_nxt = S_REQ;
            S_REQ: begin
                if (fll_ack_i)            state_nxt = S_REL;
                else if (cnt >= ACK_LIM)  state_nxt = S_REL_TO;
            end
            S_REL: begin
                if (!fll_ack_i)           state_nxt = lock_wait ? S_LOCK : S_RESP;
                else if (cnt >= ACK_LIM)  state_nxt = S_RESP;
            end
            // Hold req low for two cycles before reporting an ack timeout
            S_REL_TO: if (cnt != '0)      state_nxt = S_RESP;
            S_LOCK: begin
                if (lock_seen)            state_nxt = S_RESP;
                else if (cnt >= LOCK_LIM) state_nxt = S_RESP;
            end
            S_RESP:   if (cmd.rsp_ready_i) state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    // State register and per-state saturating cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    // Command fields are captured on accept and held until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fll_wrn_o  <= 1'b1;
            fll_add_o  <= 2'b00;
            fll_data_o <= 32'h0;
        end else if ((state == S_IDLE) && cmd.cmd_valid_i) begin
            fll_wrn_o  <= cmd.cmd_wrn_i;
            fll_add_o  <= cmd.cmd_addr_i;
            fll_data_o <= cmd.cmd_wdata_i;
        end
    end

    // Response data and status, built up as the transaction progresses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 32'h0;
            err   <= ERR_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd.cmd_valid_i) begin
                        rdata <= 32'h0;
                        err   <= ERR_OK;
                    end
                end
                S_REQ: begin
                    if (fll_ack_i)
                        rdata <= fll_wrn_o ? fll_r_data_i : 32'h0;
                    else if (cnt >= ACK_LIM)
                        err <= ERR_ACK;
                end
                S_REL: begin
                    if (fll_ack_i && (cnt >= ACK_LIM)) begin
                        rdata <= 32'h0;
                        err   <= ERR_ACK;
                    end
                end
                S_LOCK: begin
                    if (!lock_seen && (cnt >= LOCK_LIM))
                        err <= ERR_LOCK;
                end
                default: ;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous lock, plus edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            lock_prev <= 1'b0;
        end else begin
            lock_meta <= fll_lock_i;
            lock_sync <= lock_meta;
            lock_prev <= lock_sync;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fll_cfg_ctrl.sv
// ============================================================================
//  Module      : tb_fll_cfg_ctrl
//  Description : Self-checking bench for fll_cfg_ctrl with an FLL model,
//                response scoreboard and directed timing vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fll_cfg_ctrl;

    localparam int ACK_TO  = 16;
    localparam int LOCK_TO = 120;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fll_req, fll_wrn, fll_ack, fll_lock, lock_o, lock_lost;
    logic [1:0]  fll_add;
    logic [31:0] fll_data, fll_r_data;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   lost_cnt = 0;
    int   lost_bad = 0;
    bit   ack_en = 1'b1;
    logic [31:0] model_rdata = 32'h0;
    exp_t sb[$];

    fll_cfg_ctrl_if cif();

    fll_cfg_ctrl #(
        .ACK_TIMEOUT    (ACK_TO),
        .LOCK_TIMEOUT   (LOCK_TO),
        .LOCK_WAIT_MASK (4'b0011)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (cif),
        .fll_req_o    (fll_req),
        .fll_wrn_o    (fll_wrn),
        .fll_add_o    (fll_add),
        .fll_data_o   (fll_data),
        .fll_ack_i    (fll_ack),
        .fll_r_data_i (fll_r_data),
        .fll_lock_i   (fll_lock),
        .lock_o       (lock_o),
        .lock_lost_o  (lock_lost)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // FLL model: ack 3 cycles after req seen, drop ack one cycle after req falls
    initial begin
        fll_ack    = 1'b0;
        fll_r_data = 32'h0;
        forever begin
            tick();
            if (fll_req && ack_en && rst_n) begin
                repeat (3) tick();
                fll_ack    = 1'b1;
                fll_r_data = model_rdata;
                for (int i = 0; i < 64 && fll_req; i++) tick();
                tick();
                fll_ack    = 1'b0;
                fll_r_data = 32'h0;
            end
        end
    end

    // Scoreboard monitor: compare every accepted response against the queue
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && cif.rsp_valid_o && cif.rsp_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=rdata 0x%08h err %0d required=none",
                         cif.rsp_rdata_o, cif.rsp_err_o);
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", cif.rsp_rdata_o, e.rdata);
                chk("rsp_err", 32'(cif.rsp_err_o), 32'(e.err));
            end
        end
    end

    // Lock-loss pulse monitor
    initial forever begin
        @(negedge clk);
        if (lock_lost) begin
            lost_cnt++;
            if (lock_o) lost_bad++;
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic issue(input logic wrn, input logic [1:0] a, input logic [31:0] d,
                         output int t0);
        int n = 0;
        cif.cmd_valid_i = 1'b1;
        cif.cmd_wrn_i   = wrn;
        cif.cmd_addr_i  = a;
        cif.cmd_wdata_i = d;
        while (!cif.cmd_ready_o && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("cmd_accept_timeout", 32'(cif.cmd_ready_o), 32'd1);
        tick();
        cif.cmd_valid_i = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_rsp(input int t0, input int relock_at,
                            output int rel_rsp, output int rel_fall);
        rel_rsp  = -1;
        rel_fall = -1;
        for (int i = 0; i < 400; i++) begin
            if (rel_fall < 0 && !fll_req) rel_fall = cyc - t0 + 1;
            if (cif.rsp_valid_o) begin
                rel_rsp = cyc - t0 + 1;
                break;
            end
            tick();
            if (relock_at >= 0 && (cyc - t0) == relock_at) fll_lock = 1'b1;
        end
        if (rel_rsp < 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_wait actual=no_response required=response");
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cif.cmd_ready_o), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(cif.rsp_valid_o), 32'd0);
        chk({tag, "_rsp_rdata"}, cif.rsp_rdata_o, 32'd0);
        chk({tag, "_rsp_err"}, 32'(cif.rsp_err_o), 32'd0);
        chk({tag, "_fll_req"}, 32'(fll_req), 32'd0);
        chk({tag, "_fll_wrn"}, 32'(fll_wrn), 32'd1);
        chk({tag, "_fll_add"}, 32'(fll_add), 32'd0);
        chk({tag, "_fll_data"}, fll_data, 32'd0);
        chk({tag, "_lock_o"}, 32'(lock_o), 32'd0);
        chk({tag, "_lock_lost"}, 32'(lock_lost), 32'd0);
    endtask

    initial begin
        int t0, rr, rf, lost0;
        rst_n           = 1'b0;
        fll_lock        = 1'b0;
        cif.cmd_valid_i = 1'b0;
        cif.cmd_wrn_i   = 1'b1;
        cif.cmd_addr_i  = 2'd0;
        cif.cmd_wdata_i = 32'h0;
        cif.rsp_ready_i = 1'b1;
        repeat (2) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) tick();

        // Write, no lock wait (addr 2), lock low
        sb.push_back('{rdata: 32'h0, err: 2'b00});
        issue(1'b0, 2'd2, 32'hDEAD_BEEF, t0);
        chk("wr_fll_data", fll_data, 32'hDEAD_BEEF);
        wait_rsp(t0, -1, rr, rf);
        chk("wr_req_fall_cycle", 32'(rf), 32'd5);
        chk("wr_rsp_cycle", 32'(rr), 32'd7);
        tick();

        // Read addr 3 with lock low: no lock wait
        model_rdata = 32'h1234_5678;
        sb.push_back('{rdata: 32'h1234_5678, err: 2'b00});
        issue(1'b1, 2'd3, 32'h0, t0);
        wait_rsp(t0, -1, rr, rf);
        chk("rd_rsp_cycle", 32'(rr), 32'd7);
        tick();

        // Ack timeout, then a normal read
        ack_en = 1'b0;
        sb.push_back('{rdata: 32'h0, err: 2'b01});
        issue(1'b0, 2'd2, 32'h0000_0001, t0);
        wait_rsp(t0, -1, rr, rf);
        chk("to_req_fall_cycle", 32'(rf), 32'd17);
        chk("to_rsp_cycle", 32'(rr), 32'd19);
        tick();
        ack_en      = 1'b1;
        model_rdata = 32'hCAFE_0001;
        sb.push_back('{rdata: 32'hCAFE_0001, err: 2'b00});
        issue(1'b1, 2'd0, 32'h0, t0);
        wait_rsp(t0, -1, rr, rf);
        chk("after_to_rsp_cycle", 32'(rr), 32'd7);
        tick();

        // Lock-waiting write: lock drops at req, returns 100 cycles after release
        fll_lock = 1'b1;
        repeat (6) tick();
        chk("lock_o_high", 32'(lock_o), 32'd1);
        lost0 = lost_cnt;
        sb.push_back('{rdata: 32'h0, err: 2'b00});
        issue(1'b0, 2'd1, 32'h0000_0100, t0);
        fll_lock = 1'b0;
        wait_rsp(t0, 105, rr, rf);
        chk("lockwait_rsp_cycle", 32'(rr), 32'd109);
        chk("lockwait_no_lost", 32'(lost_cnt - lost0), 32'd0);
        tick();

        // Lock-waiting write with lock never returning
        lost0 = lost_cnt;
        sb.push_back('{rdata: 32'h0, err: 2'b10});
        issue(1'b0, 2'd0, 32'h0000_0200, t0);
        fll_lock = 1'b0;
        wait_rsp(t0, -1, rr, rf);
        chk("locktimeout_rsp_cycle", 32'(rr), 32'd127);
        chk("locktimeout_no_lost", 32'(lost_cnt - lost0), 32'd0);
        tick();

        // Lock loss in IDLE: exactly one pulse, coincident with lock_o low
        fll_lock = 1'b1;
        repeat (6) tick();
        lost0 = lost_cnt;
        fll_lock = 1'b0;
        repeat (6) tick();
        chk("idle_lost_pulses", 32'(lost_cnt - lost0), 32'd1);
        chk("idle_lost_lock_o_high", 32'(lost_bad), 32'd0);
        chk("idle_lock_o", 32'(lock_o), 32'd0);

        // Reset while req is high
        ack_en = 1'b0;
        issue(1'b0, 2'd3, 32'h0000_0055, t0);
        tick();
        chk("pre_reset_req", 32'(fll_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        sb.delete();
        repeat (2) tick();
        rst_n  = 1'b1;
        ack_en = 1'b1;
        repeat (2) tick();

        // Response backpressure: outputs hold while rsp_ready is low
        cif.rsp_ready_i = 1'b0;
        model_rdata     = 32'hA5A5_0003;
        sb.push_back('{rdata: 32'hA5A5_0003, err: 2'b00});
        issue(1'b1, 2'd2, 32'h0, t0);
        wait_rsp(t0, -1, rr, rf);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_rsp_valid", 32'(cif.rsp_valid_o), 32'd1);
            chk("bp_rsp_rdata", cif.rsp_rdata_o, 32'hA5A5_0003);
            chk("bp_rsp_err", 32'(cif.rsp_err_o), 32'd0);
            chk("bp_cmd_ready", 32'(cif.cmd_ready_o), 32'd0);
        end
        cif.rsp_ready_i = 1'b1;
        repeat (3) tick();
        chk("bp_back_idle", 32'(cif.cmd_ready_o), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
